axil_reg_bridge: RTL and testbench
==================================

Name: axil_reg_bridge

Overview:
- AXI4-Lite slave that converts host register accesses, arriving from the PCIe/XDMA AXI-Lite master, into the flat register-bus strobe interface (wen/addr/wdata/rdata) used by the team's register-file blocks.
- Sits directly upstream of a register file; one transaction in flight at a time.
- Write/read arbitration alternates between the two; partial-strobe writes are done as read-modify-write.

Parameters:
ADDR_WIDTH, 32, width of AXI address and reg_addr
DECODE_LIMIT, 32'h0000_0100, byte addresses >= this get DECERR, with no reg access
RMW_EN, 1, 1 = partial wstrb handled by RMW; 0 = wstrb ignored, full-word write

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  byte strobes
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
reg_wen  out  1  one-cycle write strobe to the register file
reg_addr  out  ADDR_WIDTH  register byte address, word aligned
reg_wdata  out  32  register write data
reg_rdata  in  32  combinational read data for reg_addr

Behaviour:
- Clock aclk; reset areset is synchronous and active-high.
- Reset, and areset asserted mid-transaction: every output is 0 and state returns to IDLE. An in-flight transaction is dropped with no response; last_grant = read, so the first conflict after reset goes to write.
- States: IDLE, WR_EXEC, WR_RMW, WR_RESP, RD_EXEC, RD_RESP.
- Write handshake in IDLE:
  - awready = wready = 1 only when awvalid & wvalid are both high and write wins arbitration.
  - AW and W are always accepted in the same cycle; a lone AW or lone W waits.
- Read handshake in IDLE: arready = 1 only when arvalid is high and read wins arbitration.
- Arbitration when both a write (AW+W) and a read are pending: grant the opposite of last_grant, then update last_grant. A single pending request is granted regardless of last_grant.
- Accept cycle:
  - Latch address {addr[ADDR_WIDTH-1:2],2'b00}, wdata and wstrb.
  - reg_addr updates on the next edge and holds its last value while idle.
- WR_EXEC:
  - Address >= DECODE_LIMIT: no wen, bresp = 2'b11, go to WR_RESP.
  - Else if wstrb == 4'hF, or RMW_EN == 0: reg_wen = 1 this cycle with the latched wdata, bresp = OKAY, go to WR_RESP.
  - Else: merge (reg_rdata & ~bytemask) | (wdata & bytemask) into reg_wdata, go to WR_RMW.
  - wstrb == 4'h0 with RMW_EN == 1 goes the RMW path and rewrites the current value.
- WR_RMW: reg_wen = 1 for one cycle, bresp = OKAY, go to WR_RESP.
- WR_RESP: bvalid = 1 and held until bready. On the handshake edge bvalid drops and state goes to IDLE; no new accept occurs in that same cycle.
- RD_EXEC:
  - Capture reg_rdata into s_axil_rdata, rresp = OKAY.
  - Address >= DECODE_LIMIT: rdata = 0, rresp = 2'b11.
  - Go to RD_RESP.
- RD_RESP: rvalid held until rready; rdata and rresp are stable while rvalid is high; then go to IDLE.
- reg_wen is asserted exactly once per decoded write and never during reads.
- Latencies from the accept edge:
  - bvalid: 2 cycles for a full-word write, 3 cycles for RMW.
  - rvalid: 2 cycles.
- Throughput: minimum 3 cycles per transaction, including the IDLE cycle.
- Address bits [1:0] are ignored.

Decomposition:
- Shared package axil_reg_pkg holds:
  - state enum;
  - AXI response constants RESP_OKAY = 2'b00, RESP_DECERR = 2'b11;
  - function strb_to_mask (4-bit strobe to 32-bit byte mask).
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Full write, awaddr 0x8, wdata 0xDEADBEEF, wstrb F, bready = 1 → reg_wen is a single pulse with reg_addr = 0x8 and reg_wdata = 0xDEADBEEF; bvalid 2 cycles after accept with bresp = 00.
- RMW write: register holds 0x00002222, write 0x8 with wdata 0xAABBCCDD, wstrb 4'b0101 → one reg_wen with reg_wdata = 0x00BB22DD; bvalid 3 cycles after accept.
- Read 0x10 with reg_rdata = 0x12345678 and rready held low for 5 cycles → rvalid stays high with rdata stable at 0x12345678; completes when rready rises.
- Simultaneous AW+W and AR after reset → write accepted first, read next; two further simultaneous pairs alternate read then write.
- Write to 0x100 and read of 0x104 (DECODE_LIMIT = 0x100) → no reg_wen; bresp = 11; rresp = 11 with rdata = 0.
- areset pulsed in the cycle after a write accept → no reg_wen, no bvalid, all outputs 0; a following read returns normally.

Source files
------------

// File: rtl/axil_reg_pkg.sv
// -----------------------------------------------------------------------------
// axil_reg_pkg
// Shared types and helpers for the AXI4-Lite to register-bus bridge.
//   state_t       : bridge FSM states
//   RESP_OKAY     : AXI OKAY response code
//   RESP_DECERR   : AXI DECERR response code (address outside decoded window)
//   strb_to_mask  : expands a 4-bit byte strobe into a 32-bit bit mask
// -----------------------------------------------------------------------------
package axil_reg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_EXEC,
        WR_RMW,
        WR_RESP,
        RD_EXEC,
        RD_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axil_reg_bridge.sv
// -----------------------------------------------------------------------------
// axil_reg_bridge
// AXI4-Lite slave that turns host register accesses into the flat register-bus
// strobe interface (reg_wen / reg_addr / reg_wdata / reg_rdata). One transaction
// is in flight at a time; simultaneous write and read requests are granted
// alternately. Partial-strobe writes are performed as read-modify-write.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   s_axil_aw* / s_axil_w* write address / data channels (accepted together)
//   s_axil_b*             write response channel
//   s_axil_ar*            read address channel
//   s_axil_r*             read data channel
//   reg_wen               one-cycle write strobe to the register file
//   reg_addr              word-aligned register byte address (holds while idle)
//   reg_wdata             register write data
//   reg_rdata             combinational read data for reg_addr
// -----------------------------------------------------------------------------
module axil_reg_bridge
    import axil_reg_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 32,
    parameter logic [31:0] DECODE_LIMIT = 32'h0000_0100,
    parameter bit          RMW_EN       = 1'b1
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic                  reg_wen,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [31:0]           reg_wdata,
    input  logic [31:0]           reg_rdata
);

    localparam logic [ADDR_WIDTH-1:0] LIMIT      = ADDR_WIDTH'(DECODE_LIMIT);
    // Masking (rather than slicing) keeps every address bit in use.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t     state, state_nx;
    logic       last_rd, last_rd_nx;   // 1 = read won the most recent conflict
    logic [3:0] wstrb_q;

    logic wr_req, rd_req, grant_wr, grant_rd;
    logic decerr, full_wr;

    // A write request needs both AW and W; a lone channel simply waits.
    assign wr_req   = s_axil_awvalid & s_axil_wvalid;
    assign rd_req   = s_axil_arvalid;
    assign grant_wr = wr_req & (~rd_req | last_rd);
    assign grant_rd = rd_req & (~wr_req | ~last_rd);

    assign decerr   = (reg_addr >= LIMIT);
    // With RMW disabled the strobes are ignored and every write is full-word.
    assign full_wr  = (wstrb_q == 4'hF) | ~RMW_EN;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            last_rd <= 1'b1;   // first conflict after reset goes to the write
        end else begin
            state   <= state_nx;
            last_rd <= last_rd_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and handshake / strobe outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_nx       = state;
        last_rd_nx     = last_rd;
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_arready = 1'b0;
        s_axil_bvalid  = 1'b0;
        s_axil_rvalid  = 1'b0;
        reg_wen        = 1'b0;

        case (state)
            IDLE: begin
                if (grant_wr) begin
                    s_axil_awready = 1'b1;
                    s_axil_wready  = 1'b1;
                    state_nx       = WR_EXEC;
                end else if (grant_rd) begin
                    s_axil_arready = 1'b1;
                    state_nx       = RD_EXEC;
                end
                // Only a genuine conflict moves the arbitration pointer.
                if (wr_req && rd_req) begin
                    last_rd_nx = grant_rd;
                end
            end
            WR_EXEC: begin
                if (decerr) begin
                    state_nx = WR_RESP;
                end else if (full_wr) begin
                    reg_wen  = 1'b1;
                    state_nx = WR_RESP;
                end else begin
                    state_nx = WR_RMW;
                end
            end
            WR_RMW: begin
                reg_wen  = 1'b1;
                state_nx = WR_RESP;
            end
            WR_RESP: begin
                s_axil_bvalid = 1'b1;
                if (s_axil_bready) begin
                    state_nx = IDLE;
                end
            end
            RD_EXEC: begin
                state_nx = RD_RESP;
            end
            RD_RESP: begin
                s_axil_rvalid = 1'b1;
                if (s_axil_rready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Reset wins immediately: an in-flight write must not strobe the
        // register file in the cycle reset is asserted.
        if (areset) begin
            s_axil_awready = 1'b0;
            s_axil_wready  = 1'b0;
            s_axil_arready = 1'b0;
            s_axil_bvalid  = 1'b0;
            s_axil_rvalid  = 1'b0;
            reg_wen        = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            reg_addr     <= '0;
            reg_wdata    <= '0;
            wstrb_q      <= '0;
            s_axil_bresp <= RESP_OKAY;
            s_axil_rresp <= RESP_OKAY;
            s_axil_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axil_awready) begin
                        reg_addr  <= s_axil_awaddr & ALIGN_MASK;
                        reg_wdata <= s_axil_wdata;
                        wstrb_q   <= s_axil_wstrb;
                    end else if (s_axil_arready) begin
                        reg_addr  <= s_axil_araddr & ALIGN_MASK;
                    end
                end
                WR_EXEC: begin
                    if (decerr) begin
                        s_axil_bresp <= RESP_DECERR;
                    end else begin
                        s_axil_bresp <= RESP_OKAY;
                        // reg_wdata still holds the host data here; fold in
                        // the untouched bytes of the current register value.
                        if (!full_wr) begin
                            reg_wdata <= (reg_rdata & ~strb_to_mask(wstrb_q)) |
                                         (reg_wdata &  strb_to_mask(wstrb_q));
                        end
                    end
                end
                RD_EXEC: begin
                    if (decerr) begin
                        s_axil_rdata <= '0;
                        s_axil_rresp <= RESP_DECERR;
                    end else begin
                        s_axil_rdata <= reg_rdata;
                        s_axil_rresp <= RESP_OKAY;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_axil_reg_bridge
// Self-checking bench for axil_reg_bridge. A small register-file model answers
// reg_rdata. Expected responses and register writes are queued when stimulus
// is driven and compared when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_axil_reg_bridge;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axil_awaddr;
    logic        s_axil_awvalid, s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid, s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid, s_axil_bready;
    logic [31:0] s_axil_araddr;
    logic        s_axil_arvalid, s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid, s_axil_rready;
    logic        reg_wen;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;

    always #5 aclk = ~aclk;

    axil_reg_bridge #(
        .ADDR_WIDTH(32), .DECODE_LIMIT(32'h0000_0100), .RMW_EN(1'b1)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .reg_wen(reg_wen), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
    );

    // Register file model: 64 words below 0x100, garbage above.
    logic [31:0] regs [64] = '{default: 32'h0};
    assign reg_rdata = (reg_addr < 32'h100) ? regs[reg_addr[7:2]] : 32'hA5A5_A5A5;
    always @(posedge aclk) if (reg_wen) regs[reg_addr[7:2]] <= reg_wdata;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct { bit is_wr; logic [1:0] resp; logic [31:0] data; int lat; } exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wen_t;
    typedef struct {
        bit is_wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb;
        bit wen; logic [31:0] waddr; logic [31:0] exp_data; logic [1:0] exp_resp; int exp_lat;
    } vec_t;

    exp_t exp_q[$];
    wen_t wen_q[$];
    int total = 0, bad = 0, done_cnt = 0, n_exp = 0;
    int wr_acc = 0, rd_acc = 0, b_first = 0, r_first = 0;
    bit b_seen = 0, r_seen = 0;
    logic [31:0] r_hold;
    logic [1:0]  rr_hold;
    bit m_last_rd = 1'b1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s got=timeout want=done", nm);
    endtask

    // Scoreboard side: runs every falling edge.
    task automatic monitor();
        exp_t e;
        wen_t w;
        if (reg_wen) begin
            if (wen_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_wen got=%h/%h want=none", reg_addr, reg_wdata);
            end else begin
                w = wen_q.pop_front();
                check("wen_addr", reg_addr, w.addr);
                check("wen_data", reg_wdata, w.data);
            end
        end
        if (areset) begin
            b_seen = 0;
            r_seen = 0;
            return;
        end
        if (s_axil_bvalid && !b_seen) begin
            b_seen = 1; b_first = cyc;
        end
        if (s_axil_rvalid && !r_seen) begin
            r_seen = 1; r_first = cyc; r_hold = s_axil_rdata; rr_hold = s_axil_rresp;
        end else if (s_axil_rvalid) begin
            check("rdata_stable", s_axil_rdata, r_hold);
            check("rresp_stable", 32'(s_axil_rresp), 32'(rr_hold));
        end
        if (s_axil_bvalid && s_axil_bready) begin
            b_seen = 0; done_cnt++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_b got=%h want=none", s_axil_bresp);
            end else begin
                e = exp_q.pop_front();
                check("b_kind", 32'(e.is_wr), 32'd1);
                check("bresp", 32'(s_axil_bresp), 32'(e.resp));
                check("b_latency", b_first - wr_acc, e.lat);
            end
        end
        if (s_axil_rvalid && s_axil_rready) begin
            r_seen = 0; done_cnt++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_r got=%h want=none", s_axil_rdata);
            end else begin
                e = exp_q.pop_front();
                check("r_kind", 32'(e.is_wr), 32'd0);
                check("rdata", s_axil_rdata, e.data);
                check("rresp", 32'(s_axil_rresp), 32'(e.resp));
                check("r_latency", r_first - rd_acc, e.lat);
            end
        end
    endtask

    initial forever begin
        @(negedge aclk);
        monitor();
    end

    function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input bit wen, input logic [31:0] wa,
                                input logic [31:0] x, input logic [1:0] r, input int lat);
        vec_t v;
        v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.wen = wen; v.waddr = wa;
        v.exp_data = x; v.exp_resp = r; v.exp_lat = lat;
        return v;
    endfunction

    task automatic do_reset();
        areset = 1'b1;
        s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
        s_axil_bready = 1; s_axil_rready = 1;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        m_last_rd = 1'b1;
    endtask

    // All drive tasks start and end one time unit after a rising edge.
    task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok;
        ok = 0;
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
        s_axil_awvalid = 1; s_axil_wvalid = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (s_axil_awready && s_axil_wready) begin ok = 1; wr_acc = cyc; end
            @(posedge aclk); #1;
            if (ok) break;
        end
        s_axil_awvalid = 0; s_axil_wvalid = 0;
        if (!ok) fail("wr_accept");
    endtask

    task automatic drive_rd(input logic [31:0] a);
        bit ok;
        ok = 0;
        s_axil_araddr = a; s_axil_arvalid = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (s_axil_arready) begin ok = 1; rd_acc = cyc; end
            @(posedge aclk); #1;
            if (ok) break;
        end
        s_axil_arvalid = 0;
        if (!ok) fail("rd_accept");
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_cnt >= n_exp) begin ok = 1; break; end
            @(posedge aclk); #1;
        end
        if (!ok) fail("response");
    endtask

    task automatic push_exp(input bit w, input logic [1:0] r, input logic [31:0] d, input int lat);
        exp_t e;
        e.is_wr = w; e.resp = r; e.data = d; e.lat = lat;
        exp_q.push_back(e);
        n_exp++;
    endtask

    task automatic push_wen(input logic [31:0] a, input logic [31:0] d);
        wen_t w;
        w.addr = a; w.data = d;
        wen_q.push_back(w);
    endtask

    task automatic run_vec(input vec_t v);
        push_exp(v.is_wr, v.exp_resp, v.is_wr ? 32'h0 : v.exp_data, v.exp_lat);
        if (v.wen) push_wen(v.waddr, v.exp_data);
        if (v.is_wr) drive_wr(v.addr, v.data, v.strb);
        else         drive_rd(v.addr);
        wait_done();
    endtask

    // Simultaneous AW+W and AR; the bench's own arbiter model predicts order.
    task automatic pair(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] old);
        bit wr_first, gw, gr;
        int first;
        wr_first  = m_last_rd;
        m_last_rd = !wr_first;
        if (wr_first) begin
            push_exp(1, 2'b00, 32'h0, 2);
            push_exp(0, 2'b00, wd, 2);
        end else begin
            push_exp(0, 2'b00, old, 2);
            push_exp(1, 2'b00, 32'h0, 2);
        end
        push_wen(a, wd);
        s_axil_awaddr = a; s_axil_wdata = wd; s_axil_wstrb = 4'hF; s_axil_araddr = a;
        s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_arvalid = 1;
        first = -1; gw = 0; gr = 0;
        for (int i = 0; i < 60 && !(gw && gr); i++) begin
            @(negedge aclk);
            if (!gw && s_axil_awready && s_axil_wready) begin gw = 1; wr_acc = cyc; if (first < 0) first = 1; end
            if (!gr && s_axil_arready) begin gr = 1; rd_acc = cyc; if (first < 0) first = 0; end
            @(posedge aclk); #1;
            if (gw) begin s_axil_awvalid = 0; s_axil_wvalid = 0; end
            if (gr) s_axil_arvalid = 0;
        end
        s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
        if (!(gw && gr)) fail("pair_accept");
        check("arb_write_first", first, 32'(wr_first));
        wait_done();
    endtask

    initial begin
        vec_t tbl [15];
        bit seen;
        s_axil_awaddr = 0; s_axil_wdata = 0; s_axil_wstrb = 0; s_axil_araddr = 0;

        //           wr addr           data          strb  wen waddr         exp_data      resp   lat
        tbl[0]  = mk(1, 32'h08,        32'hDEADBEEF, 4'hF, 1, 32'h08,        32'hDEADBEEF, 2'b00, 2);
        tbl[1]  = mk(0, 32'h08,        32'h0,        4'h0, 0, 32'h0,         32'hDEADBEEF, 2'b00, 2);
        tbl[2]  = mk(1, 32'h08,        32'h00002222, 4'hF, 1, 32'h08,        32'h00002222, 2'b00, 2);
        tbl[3]  = mk(1, 32'h08,        32'hAABBCCDD, 4'h5, 1, 32'h08,        32'h00BB22DD, 2'b00, 3);
        tbl[4]  = mk(0, 32'h0A,        32'h0,        4'h0, 0, 32'h0,         32'h00BB22DD, 2'b00, 2);
        tbl[5]  = mk(1, 32'h100,       32'h11111111, 4'hF, 0, 32'h0,         32'h0,        2'b11, 2);
        tbl[6]  = mk(0, 32'h104,       32'h0,        4'h0, 0, 32'h0,         32'h0,        2'b11, 2);
        tbl[7]  = mk(1, 32'h0C,        32'h12345678, 4'h0, 1, 32'h0C,        32'h00000000, 2'b00, 3);
        tbl[8]  = mk(1, 32'h0F,        32'hCAFEF00D, 4'hA, 1, 32'h0C,        32'hCA00F000, 2'b00, 3);
        tbl[9]  = mk(0, 32'h0C,        32'h0,        4'h0, 0, 32'h0,         32'hCA00F000, 2'b00, 2);
        tbl[10] = mk(1, 32'hFC,        32'h00000001, 4'hF, 1, 32'hFC,        32'h00000001, 2'b00, 2);
        tbl[11] = mk(0, 32'hFF,        32'h0,        4'h0, 0, 32'h0,         32'h00000001, 2'b00, 2);
        tbl[12] = mk(1, 32'h10,        32'h12345678, 4'hF, 1, 32'h10,        32'h12345678, 2'b00, 2);
        tbl[13] = mk(1, 32'h7FFFFFF0,  32'h55555555, 4'hF, 0, 32'h0,         32'h0,        2'b11, 2);
        tbl[14] = mk(0, 32'hFFFFFFFC,  32'h0,        4'h0, 0, 32'h0,         32'h0,        2'b11, 2);

        do_reset();
        @(negedge aclk);
        check("rst_ctrl", 32'({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid,
                               s_axil_rvalid, reg_wen, s_axil_bresp, s_axil_rresp}), 32'h0);
        check("rst_reg_addr", reg_addr, 32'h0);
        check("rst_reg_wdata", reg_wdata, 32'h0);
        check("rst_rdata", s_axil_rdata, 32'h0);
        @(posedge aclk); #1;

        for (int i = 0; i < 15; i++) run_vec(tbl[i]);

        // Read held off by rready: rvalid and rdata must stay put.
        push_exp(0, 2'b00, 32'h12345678, 2);
        s_axil_rready = 0;
        drive_rd(32'h10);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (s_axil_rvalid) begin seen = 1; break; end
        end
        if (!seen) fail("rvalid_wait");
        for (int j = 0; j < 5; j++) begin
            @(negedge aclk);
            check("stall_rvalid", 32'(s_axil_rvalid), 32'd1);
            check("stall_rdata", s_axil_rdata, 32'h12345678);
        end
        @(posedge aclk); #1 s_axil_rready = 1;
        wait_done();

        // Write response held off by bready.
        push_exp(1, 2'b00, 32'h0, 2);
        push_wen(32'h18, 32'h0BADCAFE);
        s_axil_bready = 0;
        drive_wr(32'h18, 32'h0BADCAFE, 4'hF);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (s_axil_bvalid) begin seen = 1; break; end
        end
        if (!seen) fail("bvalid_wait");
        for (int j = 0; j < 3; j++) begin
            @(negedge aclk);
            check("stall_bvalid", 32'(s_axil_bvalid), 32'd1);
        end
        @(posedge aclk); #1 s_axil_bready = 1;
        wait_done();

        // Reset in the cycle after a write accept drops the write entirely.
        drive_wr(32'h14, 32'h00000099, 4'hF);
        areset = 1'b1;
        @(negedge aclk);
        check("midrst_wen", 32'(reg_wen), 32'd0);
        check("midrst_ready", 32'({s_axil_awready, s_axil_wready, s_axil_arready,
                                   s_axil_bvalid, s_axil_rvalid}), 32'h0);
        @(posedge aclk); #1 areset = 1'b0;
        m_last_rd = 1'b1;
        @(negedge aclk);
        check("postrst_ctrl", 32'({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid,
                                   s_axil_rvalid, reg_wen, s_axil_bresp, s_axil_rresp}), 32'h0);
        check("postrst_reg_addr", reg_addr, 32'h0);
        check("postrst_reg_wdata", reg_wdata, 32'h0);
        repeat (4) @(posedge aclk);
        #1;
        check("postrst_no_bvalid", 32'(s_axil_bvalid), 32'd0);
        run_vec(mk(0, 32'h14, 32'h0, 4'h0, 0, 32'h0, 32'h00000000, 2'b00, 2));
        run_vec(mk(0, 32'h10, 32'h0, 4'h0, 0, 32'h0, 32'h12345678, 2'b00, 2));

        // Arbitration: one pair moves the pointer, reset must restore it,
        // then three pairs alternate write, read, write.
        pair(32'h20, 32'h11110001, 32'h00000000);
        do_reset();
        pair(32'h20, 32'h22220002, 32'h11110001);
        pair(32'h20, 32'h33330003, 32'h22220002);
        pair(32'h20, 32'h44440004, 32'h33330003);

        repeat (3) @(posedge aclk);
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("wen_q_empty", wen_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
